// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared types, constants and helpers for the correlation path
package corr_pkg;

   localparam int SCALAR_BITS = 32;

   typedef logic [SCALAR_BITS-1:0] fp32_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_ISSUE,
      ST_DRAIN
   } state_t;

   // Exact for values below 2**24; larger values truncate the low mantissa bits.
   function automatic fp32_t int_to_fp32(input int unsigned v);
      int          msb;
      logic [22:0] frac;
      fp32_t       f;
      f   = '0;
      msb = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) msb = i;
      end
      if (v != 0) begin
         if (msb <= 23) frac = 23'(v << (23 - msb));
         else           frac = 23'(v >> (msb - 23));
         f = {1'b0, 8'(127 + msb), frac};
      end
      return f;
   endfunction

endpackage

// File: rtl/corr_matrix_translator_if.sv
// rtl/corr_matrix_translator_if.sv - A row-read and X element-write buses
interface corr_matrix_translator_if #(
   parameter int N     = 8,
   parameter int WIDTH = corr_pkg::SCALAR_BITS
);
   localparam int AW = $clog2(N);

   logic [AW-1:0]      a_row_addr;
   logic               a_row_addr_ready;
   logic               a_row_valid;
   logic [N*WIDTH-1:0] a_row_out;
   logic [AW-1:0]      x_write_row_addr;
   logic [AW-1:0]      x_write_col_addr;
   logic [WIDTH-1:0]   x_write_data;
   logic               x_write_ready;

   modport master (
      output a_row_addr, a_row_addr_ready,
      output x_write_row_addr, x_write_col_addr, x_write_data, x_write_ready,
      input  a_row_valid, a_row_out
   );

   modport slave (
      input  a_row_addr, a_row_addr_ready,
      input  x_write_row_addr, x_write_col_addr, x_write_data, x_write_ready,
      output a_row_valid, a_row_out
   );
endinterface

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - fp32 divide by a constant, round-to-nearest-even, LATENCY-cycle pipe
module fp_divider
   import corr_pkg::*;
#(
   parameter int    LATENCY = 28,
   parameter fp32_t DIVISOR = 32'h40A0_0000
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  in_valid,
   input  fp32_t in_data,
   output logic  out_valid,
   output fp32_t out_data
);
   localparam logic [7:0]  EB = DIVISOR[30:23];
   localparam logic [23:0] MB = {1'b1, DIVISOR[22:0]};

   logic              sa, guard, sticky, carry;
   logic [7:0]        ea;
   logic [23:0]       ma, rem;
   logic [26:0]       quo;
   logic [22:0]       frac;
   logic [23:0]       frac_r;
   logic signed [9:0] exp_q;
   fp32_t             q_comb;

   fp32_t             data_pipe [LATENCY];
   logic [LATENCY-1:0] valid_pipe;

   // Quotient of the 24-bit significands scaled by 2**26 lands in [2**25, 2**27),
   // leaving a guard bit plus sticky for either normalisation.
   always_comb begin
      sa   = in_data[31] ^ DIVISOR[31];
      ea   = in_data[30:23];
      ma   = {1'b1, in_data[22:0]};
      quo  = 27'({ma, 26'b0} / {26'b0, MB});
      rem  = 24'({ma, 26'b0} % {26'b0, MB});
      if (quo[26]) begin
         frac   = quo[25:3];
         guard  = quo[2];
         sticky = (|quo[1:0]) | (|rem);
         exp_q  = $signed({2'b00, ea}) - $signed({2'b00, EB}) + 10'sd127;
      end else begin
         frac   = quo[24:2];
         guard  = quo[1];
         sticky = quo[0] | (|rem);
         exp_q  = $signed({2'b00, ea}) - $signed({2'b00, EB}) + 10'sd126;
      end
      frac_r = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
      carry  = frac_r[23];
      exp_q  = exp_q + $signed({9'b0, carry});

      if (ea == 8'hFF)             q_comb = {sa, in_data[30:0]};
      else if (ea == 8'h00)        q_comb = {sa, 31'b0};
      else if (exp_q >= 10'sd255)  q_comb = {sa, 8'hFF, 23'b0};
      else if (exp_q <= 10'sd0)    q_comb = {sa, 31'b0};
      else                         q_comb = {sa, exp_q[7:0], frac_r[22:0]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_pipe <= '0;
         for (int i = 0; i < LATENCY; i++) data_pipe[i] <= '0;
      end else begin
         valid_pipe[0] <= in_valid;
         data_pipe[0]  <= q_comb;
         for (int i = 1; i < LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            data_pipe[i]  <= data_pipe[i-1];
         end
      end
   end

   assign out_valid = valid_pipe[LATENCY-1];
   assign out_data  = data_pipe[LATENCY-1];
endmodule

// File: rtl/corr_matrix_translator.sv
// rtl/corr_matrix_translator.sv - scales the lower triangle of A by 1/NUM_SAMPLES into X
module corr_matrix_translator
   import corr_pkg::*;
#(
   parameter int N               = 8,
   parameter int NUM_SAMPLES     = 5,
   parameter int WIDTH           = 32,
   parameter int DIVIDER_LATENCY = 28,
   parameter int MEMORY_LATENCY  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic finished,
   corr_matrix_translator_if.master bus
);
   localparam int            AW       = $clog2(N);
   localparam fp32_t         DIVISOR  = int_to_fp32(NUM_SAMPLES);
   localparam logic [AW-1:0] LAST_ROW = AW'(N - 1);

   if (WIDTH != SCALAR_BITS || N < 2 || NUM_SAMPLES < 1 ||
       DIVIDER_LATENCY < 2 || MEMORY_LATENCY < 1) begin : g_bad_params
      $error("corr_matrix_translator: unsupported parameter set");
   end

   state_t             state;
   logic [AW-1:0]      r, c;
   logic [N*WIDTH-1:0] row_q;
   logic               div_in_valid;
   fp32_t              div_in_data;
   logic [AW-1:0]      issue_row, issue_col;

   logic [DIVIDER_LATENCY-1:0] tag_valid;
   logic [AW-1:0]              tag_row [DIVIDER_LATENCY];
   logic [AW-1:0]              tag_col [DIVIDER_LATENCY];

   logic  div_out_valid;
   fp32_t div_out_data;

   // Read strobe is raised on entry to REQ so it is high for exactly the REQ cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state                <= ST_IDLE;
         r                    <= '0;
         c                    <= '0;
         row_q                <= '0;
         finished             <= 1'b0;
         bus.a_row_addr       <= '0;
         bus.a_row_addr_ready <= 1'b0;
         div_in_valid         <= 1'b0;
         div_in_data          <= '0;
         issue_row            <= '0;
         issue_col            <= '0;
      end else begin
         finished             <= 1'b0;
         bus.a_row_addr_ready <= 1'b0;
         div_in_valid         <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  r                    <= '0;
                  bus.a_row_addr       <= '0;
                  bus.a_row_addr_ready <= 1'b1;
                  state                <= ST_REQ;
               end
            end
            ST_REQ: state <= ST_WAIT;
            ST_WAIT: begin
               if (bus.a_row_valid) begin
                  row_q <= bus.a_row_out;
                  c     <= '0;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               div_in_valid <= 1'b1;
               div_in_data  <= row_q[c*WIDTH +: WIDTH];
               issue_row    <= r;
               issue_col    <= c;
               c            <= c + 1'b1;
               if (c == r) begin
                  if (r == LAST_ROW) begin
                     state <= ST_DRAIN;
                  end else begin
                     r                    <= r + 1'b1;
                     bus.a_row_addr       <= r + 1'b1;
                     bus.a_row_addr_ready <= 1'b1;
                     state                <= ST_REQ;
                  end
               end
            end
            ST_DRAIN: begin
               if (!div_in_valid && tag_valid == '0) begin
                  finished <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_valid <= '0;
         for (int i = 0; i < DIVIDER_LATENCY; i++) begin
            tag_row[i] <= '0;
            tag_col[i] <= '0;
         end
      end else begin
         tag_valid[0] <= div_in_valid;
         tag_row[0]   <= issue_row;
         tag_col[0]   <= issue_col;
         for (int i = 1; i < DIVIDER_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_row[i]   <= tag_row[i-1];
            tag_col[i]   <= tag_col[i-1];
         end
      end
   end

   fp_divider #(
      .LATENCY (DIVIDER_LATENCY),
      .DIVISOR (DIVISOR)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (div_in_valid),
      .in_data   (div_in_data),
      .out_valid (div_out_valid),
      .out_data  (div_out_data)
   );

   assign bus.x_write_ready    = div_out_valid;
   assign bus.x_write_data     = div_out_data;
   assign bus.x_write_row_addr = tag_row[DIVIDER_LATENCY-1];
   assign bus.x_write_col_addr = tag_col[DIVIDER_LATENCY-1];
endmodule

// File: tb/tb_corr_matrix_translator.sv
// tb/tb_corr_matrix_translator.sv - scoreboard bench for corr_matrix_translator
module tb_corr_matrix_translator;
   localparam int N  = 4;
   localparam int NS = 5;
   localparam int DL = 28;
   localparam int ML = 2;
   localparam int W  = 32;
   localparam int AW = $clog2(N);
   localparam logic [31:0] SEVEN = 32'h40E0_0000;
   localparam logic [31:0] FIVE  = 32'h40A0_0000;
   localparam logic [31:0] ONE   = 32'h3F80_0000;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic finished;
   always #5 clk = ~clk;

   corr_matrix_translator_if #(.N(N), .WIDTH(W)) bus();

   corr_matrix_translator #(
      .N(N), .NUM_SAMPLES(NS), .WIDTH(W), .DIVIDER_LATENCY(DL), .MEMORY_LATENCY(ML)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .finished (finished),
      .bus      (bus)
   );

   typedef struct {
      logic [AW-1:0] row;
      logic [AW-1:0] col;
      logic [31:0]   data;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] amat[N][N], emat[N][N], xmem[N][N];
   bit          written[N][N];
   int          tests = 0, fails = 0, strobe_cnt = 0, fin_cnt = 0;
   int          mr, mc;
   bit          prev_strobe = 1'b0;
   bit          vp[ML];
   logic [AW-1:0] ap[ML];

   // Lower triangle of A[r][c] = 10*r+c and the hand-rounded quotients by 5, row-major.
   logic [31:0] ramp_a[10] = '{32'h0000_0000, 32'h4120_0000, 32'h4130_0000, 32'h41A0_0000,
                               32'h41A8_0000, 32'h41B0_0000, 32'h41F0_0000, 32'h41F8_0000,
                               32'h4200_0000, 32'h4204_0000};
   logic [31:0] ramp_e[10] = '{32'h0000_0000, 32'h4000_0000, 32'h400C_CCCD, 32'h4080_0000,
                               32'h4086_6666, 32'h408C_CCCD, 32'h40C0_0000, 32'h40C6_6666,
                               32'h40CC_CCCD, 32'h40D3_3333};

   task automatic check(input string name, input bit ok, input logic [31:0] act,
                        input logic [31:0] req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic bit near(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      if (a == b) return 1'b1;
      if (a[31] != b[31]) return 1'b0;
      d = a - b;
      return (d == 32'd1) || (d == 32'hFFFF_FFFF);
   endfunction

   // Row memory: answers each strobe ML cycles later, driven on falling edges.
   initial begin
      bus.a_row_valid = 1'b0;
      bus.a_row_out   = '0;
      for (int i = 0; i < ML; i++) begin vp[i] = 1'b0; ap[i] = '0; end
      forever begin
         @(negedge clk);
         bus.a_row_valid = vp[ML-1];
         for (int k = 0; k < N; k++)
            bus.a_row_out[k*W +: W] = vp[ML-1] ? amat[ap[ML-1]][k] : 32'h0;
         for (int i = ML - 1; i > 0; i--) begin vp[i] = vp[i-1]; ap[i] = ap[i-1]; end
         vp[0] = bus.a_row_addr_ready;
         ap[0] = bus.a_row_addr;
      end
   end

   // Monitor: protocol checks and scoreboard pops on every X write.
   initial forever begin
      @(negedge clk);
      if (bus.a_row_addr_ready) begin
         strobe_cnt++;
         check("strobe_width", !prev_strobe, 32'(prev_strobe), 32'd0);
      end
      prev_strobe = bus.a_row_addr_ready;
      if (finished) fin_cnt++;
      if (bus.x_write_ready) begin
         mr = int'(bus.x_write_row_addr);
         mc = int'(bus.x_write_col_addr);
         check("write_col_le_row", mc <= mr, 32'(mc), 32'(mr));
         check("write_unique", !written[mr][mc], {mr[15:0], mc[15:0]}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_write", 1'b0, {mr[15:0], mc[15:0]}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("write_addr", (bus.x_write_row_addr == e.row) && (bus.x_write_col_addr == e.col),
                  {mr[15:0], mc[15:0]}, {16'(e.row), 16'(e.col)});
            check("write_data", near(bus.x_write_data, e.data), bus.x_write_data, e.data);
         end
         written[mr][mc] = 1'b1;
         xmem[mr][mc]    = bus.x_write_data;
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic load_uniform(input logic [31:0] a, input logic [31:0] q);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin amat[r][c] = a; emat[r][c] = q; end
   endtask

   task automatic load_ramp();
      int idx = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (c <= r) begin
               amat[r][c] = ramp_a[idx];
               emat[r][c] = ramp_e[idx];
               idx++;
            end else begin
               amat[r][c] = 32'h4479_C000;
               emat[r][c] = SEVEN;
            end
         end
   endtask

   task automatic setup_run(input bit expect_writes);
      sb.delete();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            xmem[r][c]    = SEVEN;
            written[r][c] = 1'b0;
            if (expect_writes && c <= r)
               sb.push_back(exp_t'{row: AW'(r), col: AW'(c), data: emat[r][c]});
         end
      strobe_cnt = 0;
      fin_cnt    = 0;
   endtask

   task automatic wait_finish(input string name);
      int k;
      for (k = 0; k < 400; k++) begin
         step(1);
         if (fin_cnt > 0) break;
      end
      check(name, fin_cnt > 0, 32'(k), 32'd400);
   endtask

   task automatic verify(input string name);
      check({name, "_strobes"}, strobe_cnt == N, 32'(strobe_cnt), 32'(N));
      check({name, "_finished"}, fin_cnt == 1, 32'(fin_cnt), 32'd1);
      check({name, "_sb_empty"}, sb.size() == 0, 32'(sb.size()), 32'd0);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (c > r)
               check({name, "_upper"}, xmem[r][c] == SEVEN, xmem[r][c], SEVEN);
            else
               check({name, "_x"}, written[r][c] && near(xmem[r][c], emat[r][c]),
                     xmem[r][c], emat[r][c]);
         end
   endtask

   initial begin
      load_uniform(FIVE, ONE);
      setup_run(1'b0);
      step(3);
      check("rst_finished", finished == 1'b0, 32'(finished), 32'd0);
      check("rst_strobe", bus.a_row_addr_ready == 1'b0, 32'(bus.a_row_addr_ready), 32'd0);
      check("rst_write", bus.x_write_ready == 1'b0, 32'(bus.x_write_ready), 32'd0);
      check("rst_addrs", bus.a_row_addr == '0 && bus.x_write_row_addr == '0 &&
            bus.x_write_col_addr == '0, 32'(bus.a_row_addr), 32'd0);
      rst = 1'b1;
      step(2);

      load_uniform(FIVE, ONE);
      setup_run(1'b1);
      pulse_start();
      wait_finish("run_uniform_done");
      step(3);
      verify("uniform");

      load_ramp();
      setup_run(1'b1);
      pulse_start();
      wait_finish("run_ramp_done");
      step(3);
      verify("ramp");

      load_uniform(FIVE, ONE);
      amat[3][0] = 32'hC120_0000; emat[3][0] = 32'hC000_0000;
      amat[1][1] = 32'h0000_0000; emat[1][1] = 32'h0000_0000;
      amat[2][1] = 32'hC0A0_0000; emat[2][1] = 32'hBF80_0000;
      setup_run(1'b1);
      pulse_start();
      wait_finish("run_signed_done");
      verify("signed");

      // Back-to-back: start the cycle after finished, plus a stray start mid-run.
      load_ramp();
      setup_run(1'b1);
      pulse_start();
      step(15);
      pulse_start();
      wait_finish("run_b2b_done");
      step(5);
      verify("b2b");

      load_ramp();
      setup_run(1'b0);
      pulse_start();
      begin
         int k;
         for (k = 0; k < 200; k++) begin
            step(1);
            if (bus.a_row_addr_ready && bus.a_row_addr == AW'(2)) break;
         end
         check("abort_row2_seen", k < 200, 32'(k), 32'd200);
      end
      step(3);
      rst = 1'b0;
      step(1);
      check("abort_strobe", bus.a_row_addr_ready == 1'b0, 32'(bus.a_row_addr_ready), 32'd0);
      check("abort_write", bus.x_write_ready == 1'b0, 32'(bus.x_write_ready), 32'd0);
      check("abort_finished", finished == 1'b0, 32'(finished), 32'd0);
      rst = 1'b1;
      step(40);
      check("abort_no_finish", fin_cnt == 0, 32'(fin_cnt), 32'd0);
      check("abort_strobes", strobe_cnt == 3, 32'(strobe_cnt), 32'd3);

      setup_run(1'b1);
      pulse_start();
      wait_finish("run_after_reset_done");
      step(5);
      verify("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
